// File: rtl/rv32e_pkg.sv
// Shared RV32E load/store definitions: funct3 encodings, LSU state type and
// small decode helpers used by the load/store unit.
package rv32e_pkg;

  localparam int XLEN = 32;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } lsu_state_t;

  function automatic logic f3_legal(input logic is_store, input logic [2:0] f3);
    if (is_store) begin
      return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
    end
    return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
           (f3 == F3_BU) || (f3 == F3_HU);
  endfunction

  // Index of the final byte of an access (size - 1).
  function automatic logic [1:0] f3_last_byte(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   return 2'd0;
      2'b01:   return 2'd1;
      default: return 2'd3;
    endcase
  endfunction

endpackage

// File: rtl/lsu_extend.sv
// Size and sign/zero extension of an assembled little-endian load value.
module lsu_extend
  import rv32e_pkg::*;
(
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] raw,
  output logic [XLEN-1:0] value
);

  always_comb begin
    value = raw;
    case (funct3)
      F3_B:    value = {{24{raw[7]}}, raw[7:0]};
      F3_H:    value = {{16{raw[15]}}, raw[15:0]};
      F3_BU:   value = {24'd0, raw[7:0]};
      F3_HU:   value = {16'd0, raw[15:0]};
      default: value = raw;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// RV32E load/store unit driving a byte-serial req/ack memory bus and the
// register file write port for one cycle on load completion.
module load_store_unit
  import rv32e_pkg::*;
#(
  parameter int ADDR_W      = 24,
  parameter bit CHECK_ALIGN = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              is_store,
  input  logic [2:0]        funct3,
  input  logic [31:0]       base_addr,
  input  logic [11:0]       offset,
  input  logic [31:0]       store_data,
  input  logic [3:0]        rd,
  output logic              busy,
  output logic              done,
  output logic              fault,
  output logic [3:0]        write_register,
  output logic [31:0]       write_value,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata,
  input  logic              mem_ack
);

  lsu_state_t state_q, state_d;

  logic            is_store_q;
  logic            fault_q;
  logic [2:0]      funct3_q;
  logic [3:0]      rd_q;
  logic [1:0]      cnt_q;
  logic [XLEN-1:0] ea_q;
  logic [XLEN-1:0] data_q;
  logic [XLEN-1:0] asm_q;
  logic [XLEN-1:0] ext_value;

  logic [XLEN-1:0] ea;
  logic            misaligned;
  logic            start_fault;
  logic            accept;
  logic            byte_done;
  logic            last_byte;
  logic            good_load;

  assign ea = base_addr + {{20{offset[11]}}, offset};

  always_comb begin
    misaligned = 1'b0;
    if (CHECK_ALIGN) begin
      case (funct3[1:0])
        2'b01:   misaligned = ea[0];
        2'b10:   misaligned = |ea[1:0];
        default: misaligned = 1'b0;
      endcase
    end
  end

  assign start_fault = !f3_legal(is_store, funct3) || misaligned;
  assign accept      = (state_q == IDLE) && start;
  assign byte_done   = (state_q == REQ) && mem_ack;
  assign last_byte   = (cnt_q == f3_last_byte(funct3_q));

  // Stage: control state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Stage: operand capture, byte counter and load assembly
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      is_store_q <= 1'b0;
      fault_q    <= 1'b0;
      funct3_q   <= 3'd0;
      rd_q       <= 4'd0;
      cnt_q      <= 2'd0;
      ea_q       <= '0;
      data_q     <= '0;
      asm_q      <= '0;
    end else if (accept) begin
      is_store_q <= is_store;
      fault_q    <= start_fault;
      funct3_q   <= funct3;
      rd_q       <= rd;
      cnt_q      <= 2'd0;
      ea_q       <= ea;
      data_q     <= store_data;
      asm_q      <= '0;
    end else if (byte_done) begin
      if (!is_store_q) begin
        asm_q[{cnt_q, 3'b000} +: 8] <= mem_rdata;
      end
      cnt_q <= cnt_q + 2'd1;
    end
  end

  lsu_extend u_extend (
    .funct3 (funct3_q),
    .raw    (asm_q),
    .value  (ext_value)
  );

  // Stage: next state and outputs
  always_comb begin
    state_d        = state_q;
    busy           = 1'b0;
    done           = 1'b0;
    fault          = 1'b0;
    good_load      = 1'b0;
    write_register = 4'd0;
    write_value    = '0;
    mem_req        = 1'b0;
    mem_we         = 1'b0;
    mem_addr       = '0;
    mem_wdata      = 8'd0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = start_fault ? DONE : REQ;
        end
      end
      REQ: begin
        busy      = 1'b1;
        mem_req   = 1'b1;
        mem_we    = is_store_q;
        mem_addr  = ADDR_W'(ea_q + {30'd0, cnt_q});
        mem_wdata = data_q[{cnt_q, 3'b000} +: 8];
        if (mem_ack && last_byte) begin
          state_d = DONE;
        end
      end
      DONE: begin
        busy      = 1'b1;
        done      = 1'b1;
        fault     = fault_q;
        good_load = !fault_q && !is_store_q;
        if (good_load) begin
          write_register = rd_q;
          write_value    = ext_value;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule
